// File: rtl/vga_timing_gen_if.sv
// Raster output bundle from vga_timing_gen to the pattern/colour stage.
// Ports: xcounter/ycounter (pixel position), h_sync/v_sync, active, line_start,
//        frame_start, plus frame_cnt when VGA_FRAME_CNT_EN is defined.
// Modports: master = timing generator (drives everything), slave = consumer.
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
`ifdef VGA_FRAME_CNT_EN
  , parameter int FRAME_W = 8
`endif
);
  logic [CNT_W-1:0]   xcounter;
  logic [CNT_W-1:0]   ycounter;
  logic               h_sync;
  logic               v_sync;
  logic               active;
  logic               line_start;
  logic               frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt;

  modport master (output xcounter, ycounter, h_sync, v_sync, active,
                         line_start, frame_start, frame_cnt);
  modport slave  (input  xcounter, ycounter, h_sync, v_sync, active,
                         line_start, frame_start, frame_cnt);
`else
  modport master (output xcounter, ycounter, h_sync, v_sync, active,
                         line_start, frame_start);
  modport slave  (input  xcounter, ycounter, h_sync, v_sync, active,
                         line_start, frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator on a single clock, advanced by a pix_en strobe.
// Latency: all outputs registered; they describe the pixel on xcounter/ycounter.
// Backpressure: none; pix_en=0 freezes the raster and suppresses the pulses.
// Ports: clk, reset (sync, active-high), pix_en, vga (vga_timing_gen_if.master).
// Optional macro VGA_FRAME_CNT_EN adds parameter FRAME_W and output vga.frame_cnt.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10
`ifdef VGA_FRAME_CNT_EN
  , parameter int FRAME_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

  localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(HS_FIRST);
  localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(HS_LAST);
  localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(VS_FIRST);
  localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(VS_LAST);

  if ((2 ** CNT_W) < H_TOTAL || (2 ** CNT_W) < V_TOTAL) begin : g_cnt_w_check
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CNT_W-1:0] x_q, y_q;
  logic [CNT_W-1:0] x_nxt, y_nxt;
  logic             h_sync_q, v_sync_q, active_q, line_start_q, frame_start_q;
  logic             x_wrap, y_wrap;
  logic             hs_on_nxt, vs_on_nxt, active_nxt, line_nxt, frame_nxt;

  // Decodes look at the position being advanced to, so the registered syncs
  // and active flag line up with the registered counters without skew.
  always_comb begin
    x_wrap     = (x_q == X_LAST);
    y_wrap     = (y_q == Y_LAST);
    x_nxt      = x_wrap ? '0 : x_q + CNT_W'(1);
    y_nxt      = y_q;
    if (x_wrap) begin
      y_nxt = y_wrap ? '0 : y_q + CNT_W'(1);
    end
    hs_on_nxt  = (x_nxt >= HS_LO) && (x_nxt <= HS_HI);
    vs_on_nxt  = (y_nxt >= VS_LO) && (y_nxt <= VS_HI);
    active_nxt = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
    line_nxt   = (x_nxt == '0);
    frame_nxt  = line_nxt && (y_nxt == '0);
  end

  // Reset parks the raster on the last pixel of the frame so the first
  // pix_en afterwards lands on (0,0) with both start pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q           <= X_LAST;
      y_q           <= Y_LAST;
      h_sync_q      <= ~SYNC_POL;
      v_sync_q      <= ~SYNC_POL;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pix_en) begin
      x_q           <= x_nxt;
      y_q           <= y_nxt;
      h_sync_q      <= hs_on_nxt ? SYNC_POL : ~SYNC_POL;
      v_sync_q      <= vs_on_nxt ? SYNC_POL : ~SYNC_POL;
      active_q      <= active_nxt;
      line_start_q  <= line_nxt;
      frame_start_q <= frame_nxt;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign vga.xcounter    = x_q;
  assign vga.ycounter    = y_q;
  assign vga.h_sync      = h_sync_q;
  assign vga.v_sync      = v_sync_q;
  assign vga.active      = active_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_q;

  // Counts on the same edge that raises frame_start; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (pix_en && frame_nxt) begin
      frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced raster so whole frames fit
// in a short run: 16+2+4+3 = 25 pixels/line, 8+2+2+3 = 15 lines/frame,
// h_sync on x=18..21, v_sync on y=10..11, active-low syncs.
module tb_vga_timing_gen;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = 25, VT = 15;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset;
  logic pix_en;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

`ifdef VGA_FRAME_CNT_EN
  vga_timing_gen_if #(.CNT_W(CW), .FRAME_W(2)) vif ();
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .CNT_W(CW), .FRAME_W(2)
  ) dut (.clk(clk), .reset(reset), .pix_en(pix_en), .vga(vif.master));
`else
  vga_timing_gen_if #(.CNT_W(CW)) vif ();
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .CNT_W(CW)
  ) dut (.clk(clk), .reset(reset), .pix_en(pix_en), .vga(vif.master));
`endif

  // Advance one clock and land on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_en = 1'b1;
    repeat (3) tick();
    checks++; if (vif.xcounter !== 5'd24) begin errors++; $display("FAIL rst_x: got %0d expected 24", vif.xcounter); end
    checks++; if (vif.ycounter !== 5'd14) begin errors++; $display("FAIL rst_y: got %0d expected 14", vif.ycounter); end
    checks++; if (vif.active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b expected 0", vif.active); end
    checks++; if (vif.h_sync !== 1'b1 || vif.v_sync !== 1'b1) begin errors++; $display("FAIL rst_sync: got hs=%b vs=%b expected 1/1", vif.h_sync, vif.v_sync); end
    checks++; if (vif.line_start !== 1'b0 || vif.frame_start !== 1'b0) begin errors++; $display("FAIL rst_pulses: got ls=%b fs=%b expected 0/0", vif.line_start, vif.frame_start); end
    reset = 1'b0;
    tick();
    checks++; if (vif.xcounter !== 5'd0 || vif.ycounter !== 5'd0) begin errors++; $display("FAIL first_pix: got (%0d,%0d) expected (0,0)", vif.xcounter, vif.ycounter); end
    checks++; if (vif.active !== 1'b1) begin errors++; $display("FAIL first_active: got %b expected 1", vif.active); end
    checks++; if (vif.line_start !== 1'b1 || vif.frame_start !== 1'b1) begin errors++; $display("FAIL first_pulses: got ls=%b fs=%b expected 1/1", vif.line_start, vif.frame_start); end
    tick();
    checks++; if (vif.xcounter !== 5'd1) begin errors++; $display("FAIL second_x: got %0d expected 1", vif.xcounter); end
    checks++; if (vif.line_start !== 1'b0 || vif.frame_start !== 1'b0) begin errors++; $display("FAIL second_pulses: got ls=%b fs=%b expected 0/0", vif.line_start, vif.frame_start); end
  endtask

  // Continues from (1,0) with pix_en held high through the end of line 0.
  task automatic test_line();
    int ex = 1, xerr = 0, hs_low = 0, first_hs = -1, act_fall = -1, ls_cnt = 0;
    logic prev_act = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      ex = (ex + 1) % HT;
      if (vif.xcounter !== ex[CW-1:0]) xerr++;
      if (vif.h_sync === 1'b0) begin
        hs_low++;
        if (first_hs < 0) first_hs = int'(vif.xcounter);
      end
      if (prev_act && !vif.active && act_fall < 0) act_fall = int'(vif.xcounter);
      prev_act = vif.active;
      if (vif.line_start) ls_cnt++;
    end
    checks++; if (xerr != 0) begin errors++; $display("FAIL line_x_seq: got %0d bad cycles expected 0", xerr); end
    checks++; if (hs_low != HS) begin errors++; $display("FAIL line_hs_width: got %0d expected %0d", hs_low, HS); end
    checks++; if (first_hs != 18) begin errors++; $display("FAIL line_hs_start: got x=%0d expected 18", first_hs); end
    checks++; if (act_fall != HA) begin errors++; $display("FAIL line_active_fall: got x=%0d expected %0d", act_fall, HA); end
    checks++; if (vif.xcounter !== 5'd0 || vif.ycounter !== 5'd1) begin errors++; $display("FAIL line_wrap: got (%0d,%0d) expected (0,1)", vif.xcounter, vif.ycounter); end
    checks++; if (vif.line_start !== 1'b1 || vif.frame_start !== 1'b0) begin errors++; $display("FAIL line_wrap_pulses: got ls=%b fs=%b expected 1/0", vif.line_start, vif.frame_start); end
    checks++; if (ls_cnt != 1) begin errors++; $display("FAIL line_ls_count: got %0d expected 1", ls_cnt); end
    tick();
    checks++; if (vif.line_start !== 1'b0 || vif.xcounter !== 5'd1) begin errors++; $display("FAIL line_ls_width: got ls=%b x=%0d expected 0/1", vif.line_start, vif.xcounter); end
  endtask

  task automatic test_full_frame();
    int fs_cnt = 0, act_cnt = 0, vs_low = 0, vs_bad = 0, ls_cnt = 0;
    logic in_vs;
    reset = 1'b1; pix_en = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < HT * VT; i++) begin
      tick();
      in_vs = (vif.ycounter >= 5'd10) && (vif.ycounter <= 5'd11);
      if (vif.frame_start) fs_cnt++;
      if (vif.line_start) ls_cnt++;
      if (vif.active) act_cnt++;
      if (vif.v_sync === 1'b0) vs_low++;
      if ((vif.v_sync === 1'b0) != in_vs) vs_bad++;
    end
    checks++; if (fs_cnt != 1) begin errors++; $display("FAIL frame_fs_count: got %0d expected 1", fs_cnt); end
    checks++; if (ls_cnt != VT) begin errors++; $display("FAIL frame_ls_count: got %0d expected %0d", ls_cnt, VT); end
    checks++; if (act_cnt != HA * VA) begin errors++; $display("FAIL frame_active_count: got %0d expected %0d", act_cnt, HA * VA); end
    checks++; if (vs_low != HT * VS) begin errors++; $display("FAIL frame_vs_width: got %0d expected %0d", vs_low, HT * VS); end
    checks++; if (vs_bad != 0) begin errors++; $display("FAIL frame_vs_place: got %0d misplaced cycles expected 0", vs_bad); end
    tick();
    checks++; if (vif.frame_start !== 1'b1 || vif.xcounter !== 5'd0 || vif.ycounter !== 5'd0) begin errors++; $display("FAIL frame_period: got fs=%b (%0d,%0d) expected 1 (0,0)", vif.frame_start, vif.xcounter, vif.ycounter); end
  endtask

  task automatic test_toggle();
    int ex = HT - 1, ey = VT - 1, perr = 0, ls_cnt = 0, ls_idle = 0;
    reset = 1'b1; pix_en = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      pix_en = (i % 2 == 0);
      tick();
      if (pix_en) begin
        if (ex == HT - 1) begin
          ex = 0;
          ey = (ey == VT - 1) ? 0 : ey + 1;
        end else begin
          ex = ex + 1;
        end
      end
      if (vif.xcounter !== ex[CW-1:0] || vif.ycounter !== ey[CW-1:0]) perr++;
      if (vif.line_start) begin
        ls_cnt++;
        if (!pix_en) ls_idle++;
      end
    end
    checks++; if (perr != 0) begin errors++; $display("FAIL toggle_pos: got %0d bad cycles expected 0", perr); end
    checks++; if (ls_cnt != 2) begin errors++; $display("FAIL toggle_ls_count: got %0d expected 2", ls_cnt); end
    checks++; if (ls_idle != 0) begin errors++; $display("FAIL toggle_ls_idle: got %0d expected 0", ls_idle); end
    checks++; if (vif.xcounter !== 5'd24 || vif.ycounter !== 5'd1) begin errors++; $display("FAIL toggle_end: got (%0d,%0d) expected (24,1)", vif.xcounter, vif.ycounter); end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1; pix_en = 1'b0;
    tick();
    reset = 1'b0; pix_en = 1'b1;
    repeat (133) tick();
    checks++; if (vif.xcounter !== 5'd7 || vif.ycounter !== 5'd5 || vif.active !== 1'b1) begin errors++; $display("FAIL mid_pos: got (%0d,%0d) act=%b expected (7,5) act=1", vif.xcounter, vif.ycounter, vif.active); end
    reset = 1'b1;
    tick();
    checks++; if (vif.xcounter !== 5'd24 || vif.ycounter !== 5'd14) begin errors++; $display("FAIL mid_rst_pos: got (%0d,%0d) expected (24,14)", vif.xcounter, vif.ycounter); end
    checks++; if (vif.active !== 1'b0 || vif.h_sync !== 1'b1 || vif.v_sync !== 1'b1) begin errors++; $display("FAIL mid_rst_flags: got act=%b hs=%b vs=%b expected 0/1/1", vif.active, vif.h_sync, vif.v_sync); end
    reset = 1'b0; pix_en = 1'b0;
    tick();
    checks++; if (vif.xcounter !== 5'd24 || vif.line_start !== 1'b0) begin errors++; $display("FAIL idle_hold: got x=%0d ls=%b expected 24/0", vif.xcounter, vif.line_start); end
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_cnt();
    reset = 1'b1; pix_en = 1'b1;
    tick();
    checks++; if (vif.frame_cnt !== 2'd0) begin errors++; $display("FAIL fcnt_rst: got %0d expected 0", vif.frame_cnt); end
    reset = 1'b0;
    repeat (3 * HT * VT) tick();
    checks++; if (vif.frame_cnt !== 2'd3) begin errors++; $display("FAIL fcnt_three: got %0d expected 3", vif.frame_cnt); end
    tick();
    checks++; if (vif.frame_cnt !== 2'd0 || vif.frame_start !== 1'b1) begin errors++; $display("FAIL fcnt_wrap: got %0d fs=%b expected 0 fs=1", vif.frame_cnt, vif.frame_start); end
    repeat (HT * VT) tick();
    checks++; if (vif.frame_cnt !== 2'd1) begin errors++; $display("FAIL fcnt_after_wrap: got %0d expected 1", vif.frame_cnt); end
    reset = 1'b1;
    tick();
    checks++; if (vif.frame_cnt !== 2'd0) begin errors++; $display("FAIL fcnt_rst2: got %0d expected 0", vif.frame_cnt); end
    reset = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    pix_en = 1'b0;
    test_reset();
    test_line();
    test_full_frame();
    test_toggle();
    test_mid_reset();
`ifdef VGA_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Single-clock VGA raster timing generator. It produces the pixel coordinates, sync pulses and active-video flag that the pattern/colour stage consumes.
- Replaces the divided-clock sync path: it runs on the system clock and advances on a one-cycle pixel enable strobe from the clock-enable divider, so downstream logic stays in one clock domain.
- Defaults give 640x480 @ 60 Hz from a 50 MHz clk with pix_en every 2nd cycle.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of h_sync/v_sync (0 = active-low)
- CNT_W, 10, width of xcounter/ycounter

Ports:
- clk  input  1  system clock; the only clock
- reset  input  1  synchronous, active-high reset
- pix_en  input  1  pixel strobe; raster advances one pixel on each clk edge where pix_en=1
- xcounter  output  CNT_W  current pixel column, 0..H_TOTAL-1
- ycounter  output  CNT_W  current line, 0..V_TOTAL-1
- h_sync  output  1  horizontal sync, level per SYNC_POL
- v_sync  output  1  vertical sync, level per SYNC_POL
- active  output  1  1 when xcounter<H_ACTIVE and ycounter<V_ACTIVE
- line_start  output  1  one-clk pulse on the first clk cycle showing xcounter=0
- frame_start  output  1  one-clk pulse on the first clk cycle showing xcounter=0, ycounter=0

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Derived totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Elaboration error if 2**CNT_W < max(H_TOTAL, V_TOTAL).
- All outputs are registered. h_sync, v_sync and active always describe the pixel currently shown on xcounter/ycounter, with zero skew between them.
- Reset values (next clk after reset=1, regardless of pix_en):
  - xcounter=H_TOTAL-1, ycounter=V_TOTAL-1
  - active=0, h_sync=v_sync=~SYNC_POL (inactive)
  - line_start=0, frame_start=0
- Consequence: the first pix_en after reset presents pixel (0,0).
- Advance on pix_en=1:
  - If xcounter=H_TOTAL-1: xcounter<=0, and ycounter<=(ycounter=V_TOTAL-1) ? 0 : ycounter+1.
  - Otherwise: xcounter<=xcounter+1, ycounter unchanged.
- Decodes are computed from the next counter values, registered alongside the counters:
  - h_sync active when next x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
  - v_sync active when next y is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491).
- line_start <= pix_en & (next x==0); frame_start additionally requires next y==0. Both pulses are exactly one clk wide even when pix_en is held high.
- pix_en=0: counters, syncs and active hold; line_start and frame_start are 0.
- Reset mid-frame: the reset value applies on the next clk edge and overrides a coincident pix_en.

Optional Feature:
- Macro VGA_FRAME_CNT_EN.
- Defined: adds parameter FRAME_W (default 8) and output frame_cnt[FRAME_W-1:0].
  - Reset value 0.
  - Increments on the clk edge that asserts frame_start.
  - Wraps 2**FRAME_W-1 -> 0.
  - Used for animated patterns.
- Undefined: no frame_cnt port, no counter logic, all other behaviour identical.

Test Plan:
- Reset 3 clks, then pix_en=1 continuously -> first post-reset clk shows x=0, y=0, active=1, line_start=1, frame_start=1; next clk x=1, both pulses 0.
- pix_en=1 continuously for one line:
  - h_sync goes low exactly when x=656 and stays low for 96 clks.
  - active falls at x=640.
  - x=799 -> 0 with y 0 -> 1 and line_start=1 for one clk.
- Full frame with pix_en=1 (420000 clks):
  - v_sync low only for y=490..491 (1600 clks).
  - frame_start pulses exactly once per 420000 clks.
  - active count is 307200.
- pix_en toggling 1,0,1,0 -> counters advance once per 2 clks; line_start high one clk only; 840000 clks per frame.
- Reset asserted at x=300, y=200 together with pix_en=1 -> next clk x=799, y=524, active=0, h_sync=v_sync=1.
- With VGA_FRAME_CNT_EN defined:
  - After 3 full frames, frame_cnt=3.
  - With FRAME_W=2, frame_cnt wraps 3 -> 0 on the 4th frame_start.
  - Reset returns frame_cnt to 0.
